// File: rtl/sym_pattern_gen_if.sv
// rtl/sym_pattern_gen_if.sv - output word stream of the symmetry pattern generator
//
// Ports (master = generator, slave = consumer):
//   out_valid  master->slave  word, mismatch count and sym flag are valid
//   out_ready  slave->master  consumer accepts the word on a valid&ready edge
//   out_word   master->slave  generated WIDTH-bit word
//   out_mm     master->slave  mirrored-pair mismatch count of out_word
//   out_sym    master->slave  1 when out_mm == 0
interface sym_pattern_gen_if #(
  parameter int WIDTH = 8
);
  localparam int MMW = $clog2(WIDTH / 2) + 1;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [MMW-1:0]   out_mm;
  logic             out_sym;

  modport master (
    output out_valid,
    output out_word,
    output out_mm,
    output out_sym,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_word,
    input  out_mm,
    input  out_sym,
    output out_ready
  );
endinterface

// File: rtl/sym_pattern_gen.sv
// rtl/sym_pattern_gen.sv - stimulus source of words with a requested mirrored-pair mismatch count
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   start      begin a run; only looked at while idle
//   target_mm  requested mismatched pairs, clamped to WIDTH/2
//   count      number of words in the run (0 gives an empty run)
//   pat        output word stream (sym_pattern_gen_if master)
//   busy       high while words are being emitted
//   done       one-cycle pulse at the end of a run
module sym_pattern_gen #(
  parameter int          WIDTH = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(WIDTH/2):0]     target_mm,
  input  logic [7:0]                   count,
  sym_pattern_gen_if.master            pat,
  output logic                         busy,
  output logic                         done
);

  localparam int H   = WIDTH / 2;
  localparam int RW  = $clog2(H);
  localparam int MMW = RW + 1;

  // An all-zero LFSR would lock up, so a zero seed is nudged to 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [MMW-1:0]   tm_q;
  logic [7:0]       remaining;

  logic [MMW-1:0]   tm_in;
  logic [MMW-1:0]   tm_sel;
  logic             lfsr_fb;
  logic [15:0]      lfsr_nx;
  logic [H-1:0]     therm;
  logic [RW-1:0]    rot;
  logic [2*H-1:0]   therm_dbl;
  logic [H-1:0]     mask;
  logic [H-1:0]     low;
  logic [WIDTH-1:0] word_nx;

  // Requested count clamped to the number of mirrored pairs. The first word of
  // a run is built on the start edge, before tm_q holds the latched value.
  always_comb begin
    tm_in  = (target_mm > MMW'(H)) ? MMW'(H) : target_mm;
    tm_sel = (state == IDLE) ? tm_in : tm_q;
  end

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  always_comb begin
    lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    lfsr_nx = {lfsr_fb, lfsr[15:1]};
  end

  // Word builder: the low half comes straight from the LFSR, the high half is
  // its mirror with exactly tm_sel pairs flipped. The flip mask is a
  // thermometer code rotated by an LFSR-chosen amount; rot is RW bits wide and
  // H = 2**RW, so the rotation amount is already reduced mod H.
  always_comb begin
    therm = '0;
    for (int i = 0; i < H; i++) begin
      therm[i] = (MMW'(i) < tm_sel);
    end
    rot       = lfsr[H+RW-1:H];
    therm_dbl = {therm, therm} << rot;
    mask      = therm_dbl[2*H-1:H];
    low       = lfsr[H-1:0];
    word_nx   = '0;
    for (int i = 0; i < H; i++) begin
      word_nx[i]           = low[i];
      word_nx[WIDTH-1-i]   = low[i] ^ mask[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= SEED_EFF;
      tm_q          <= '0;
      remaining     <= 8'd0;
      pat.out_valid <= 1'b0;
      pat.out_word  <= '0;
      pat.out_mm    <= '0;
      pat.out_sym   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            tm_q <= tm_in;
            if (count == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state         <= SEND;
              busy          <= 1'b1;
              remaining     <= count;
              pat.out_valid <= 1'b1;
              pat.out_word  <= word_nx;
              pat.out_mm    <= tm_sel;
              pat.out_sym   <= (tm_sel == '0);
              lfsr          <= lfsr_nx;
            end
          end
        end

        SEND: begin
          // out_valid is always high here; hold the word until accepted.
          if (pat.out_ready) begin
            if (remaining > 8'd1) begin
              remaining    <= remaining - 8'd1;
              pat.out_word <= word_nx;
              pat.out_mm   <= tm_sel;
              pat.out_sym  <= (tm_sel == '0);
              lfsr         <= lfsr_nx;
            end else begin
              state         <= DONE;
              pat.out_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state         <= IDLE;
          pat.out_valid <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sym_pattern_gen.sv
// tb/tb_sym_pattern_gen.sv - directed self-checking bench for sym_pattern_gen (WIDTH=8)
module tb_sym_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] target_mm;
  logic [7:0] count;
  logic       busy;
  logic       done;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  pal_exp [4];
  logic [7:0]  first   [2];

  sym_pattern_gen_if #(.WIDTH(8)) bus ();

  sym_pattern_gen #(.WIDTH(8), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .target_mm (target_mm),
    .count     (count),
    .pat       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] m_next(input logic [15:0] r);
    logic [15:0] b;
    b = ((r >> 0) ^ (r >> 2) ^ (r >> 3) ^ (r >> 5)) & 16'h0001;
    return (r >> 1) | (b << 15);
  endfunction

  function automatic logic [7:0] m_word(input logic [15:0] r, input int tm);
    int         t;
    int         rt;
    logic [3:0] m;
    logic [7:0] w;
    t  = (tm > 4) ? 4 : tm;
    rt = int'((r >> 4) & 16'h0003) % 4;
    m  = 4'b0000;
    for (int k = 0; k < t; k++) m[(k + rt) % 4] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w[i]     = r[i];
      w[7 - i] = r[i] ^ m[i];
    end
    return w;
  endfunction

  function automatic int pairs_diff(input logic [7:0] w);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (w[i] != w[7 - i]) n++;
    return n;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; target_mm = 3'd1; count = 8'd3; bus.out_ready = 1'b1;
    tick; tick;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    vectors++; if (bus.out_word !== 8'h00) begin miscompares++; $display("FAIL reset_word got=%h exp=00", bus.out_word); end
    vectors++; if (bus.out_mm !== 3'd0) begin miscompares++; $display("FAIL reset_mm got=%0d exp=0", bus.out_mm); end
    vectors++; if (bus.out_sym !== 1'b0) begin miscompares++; $display("FAIL reset_sym got=%b exp=0", bus.out_sym); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0; start = 1'b0;
    tick;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid got=%b exp=0", bus.out_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL post_reset_done got=%b exp=0", done); end
    m_lfsr = 16'hACE1;
  endtask

  task automatic test_palindrome;
    // SEED 0xACE1 stepped by the LFSR: ACE1, 5670, AB38, 559C; tm=0 mirrors the low nibble.
    pal_exp[0] = 8'h81; pal_exp[1] = 8'h00; pal_exp[2] = 8'h18; pal_exp[3] = 8'h3C;
    target_mm = 3'd0; count = 8'd4; bus.out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL pal_valid[%0d] got=%b exp=1", k, bus.out_valid); end
      vectors++; if (bus.out_word !== pal_exp[k]) begin miscompares++; $display("FAIL pal_word[%0d] got=%h exp=%h", k, bus.out_word, pal_exp[k]); end
      vectors++; if (pairs_diff(bus.out_word) !== 0) begin miscompares++; $display("FAIL pal_mirror[%0d] got=%0d exp=0", k, pairs_diff(bus.out_word)); end
      vectors++; if (bus.out_sym !== 1'b1 || bus.out_mm !== 3'd0) begin miscompares++; $display("FAIL pal_flags[%0d] got=sym%b/mm%0d exp=sym1/mm0", k, bus.out_sym, bus.out_mm); end
      vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL pal_busy[%0d] got=busy%b/done%b exp=busy1/done0", k, busy, done); end
      m_lfsr = m_next(m_lfsr);
      tick;
    end
    vectors++; if (done !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL pal_done got=done%b/valid%b/busy%b exp=1/0/0", done, bus.out_valid, busy); end
    tick;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL pal_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_full_mismatch;
    logic [7:0] exp_w;
    target_mm = 3'd4; count = 8'd3; bus.out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start = 1'b0;
      exp_w = m_word(m_lfsr, 4);
      m_lfsr = m_next(m_lfsr);
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_word !== exp_w) begin miscompares++; $display("FAIL fm_word[%0d] got=%h exp=%h", k, bus.out_word, exp_w); end
      vectors++; if (bus.out_word[7:4] !== ~rev4(bus.out_word[3:0])) begin miscompares++; $display("FAIL fm_invmirror[%0d] got=%h exp=%h", k, bus.out_word[7:4], ~rev4(bus.out_word[3:0])); end
      vectors++; if (bus.out_mm !== 3'd4 || bus.out_sym !== 1'b0) begin miscompares++; $display("FAIL fm_flags[%0d] got=mm%0d/sym%b exp=mm4/sym0", k, bus.out_mm, bus.out_sym); end
      if (k == 1) begin
        // Mid-run start and input changes must have no effect.
        start = 1'b1; target_mm = 3'd0; count = 8'd9;
      end
      tick;
    end
    start = 1'b0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL fm_done got=%b exp=1", done); end
    tick;
    vectors++; if (bus.out_valid !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL fm_idle got=valid%b/done%b exp=0/0", bus.out_valid, done); end
  endtask

  task automatic test_stall;
    logic [7:0] cur;
    int         accepts;
    bit         seen_done;
    target_mm = 3'd2; count = 8'd5; bus.out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    cur = m_word(m_lfsr, 2);
    m_lfsr = m_next(m_lfsr);
    accepts = 0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 30 && !seen_done; cyc++) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_word !== cur) begin miscompares++; $display("FAIL stall_word[cyc%0d] got=%h/v%b exp=%h/v1", cyc, bus.out_word, bus.out_valid, cur); end
        vectors++; if (pairs_diff(bus.out_word) !== 2) begin miscompares++; $display("FAIL stall_pairs[cyc%0d] got=%0d exp=2", cyc, pairs_diff(bus.out_word)); end
        bus.out_ready = !(cyc >= 2 && cyc < 5);
        if (bus.out_ready) begin
          accepts++;
          if (accepts < 5) begin
            cur = m_word(m_lfsr, 2);
            m_lfsr = m_next(m_lfsr);
          end
        end
        tick;
      end
    end
    bus.out_ready = 1'b1;
    vectors++; if (accepts !== 5) begin miscompares++; $display("FAIL stall_accepts got=%0d exp=5", accepts); end
    vectors++; if (seen_done !== 1'b1) begin miscompares++; $display("FAIL stall_done got=%b exp=1", seen_done); end
    tick;
  endtask

  task automatic test_count_zero;
    logic [7:0] exp_w;
    target_mm = 3'd1; count = 8'd0; bus.out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    vectors++; if (done !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_done got=done%b/valid%b/busy%b exp=1/0/0", done, bus.out_valid, busy); end
    tick;
    vectors++; if (done !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_after got=done%b/valid%b exp=0/0", done, bus.out_valid); end
    target_mm = 3'd7; count = 8'd1; start = 1'b1;
    tick;
    start = 1'b0;
    exp_w = m_word(m_lfsr, 7);
    m_lfsr = m_next(m_lfsr);
    vectors++; if (bus.out_mm !== 3'd4 || bus.out_sym !== 1'b0) begin miscompares++; $display("FAIL clamp_mm got=mm%0d/sym%b exp=mm4/sym0", bus.out_mm, bus.out_sym); end
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_word !== exp_w) begin miscompares++; $display("FAIL clamp_word got=%h exp=%h", bus.out_word, exp_w); end
    tick;
    vectors++; if (done !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL clamp_done got=done%b/valid%b exp=1/0", done, bus.out_valid); end
    tick;
  endtask

  task automatic test_reset_midrun;
    logic [7:0] exp_w;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    target_mm = 3'd1; count = 8'd6; bus.out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    first[0] = bus.out_word;
    tick;
    first[1] = bus.out_word;
    // m_word(ACE1, 1): low nibble 1, rotation 2 -> 8'hA1.
    vectors++; if (first[0] !== 8'hA1) begin miscompares++; $display("FAIL mid_word0 got=%h exp=a1", first[0]); end
    exp_w = m_word(m_next(16'hACE1), 1);
    vectors++; if (first[1] !== exp_w) begin miscompares++; $display("FAIL mid_word1 got=%h exp=%h", first[1], exp_w); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_idle got=valid%b/busy%b/done%b exp=0/0/0", bus.out_valid, busy, done); end
    vectors++; if (bus.out_word !== 8'h00 || bus.out_mm !== 3'd0) begin miscompares++; $display("FAIL mid_clear got=%h/mm%0d exp=00/mm0", bus.out_word, bus.out_mm); end
    tick;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_no_done got=%b exp=0", done); end
    m_lfsr = 16'hACE1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_w = m_word(m_lfsr, 1);
      m_lfsr = m_next(m_lfsr);
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_word !== exp_w) begin miscompares++; $display("FAIL rerun_word[%0d] got=%h exp=%h", k, bus.out_word, exp_w); end
      if (k < 2) begin
        vectors++; if (bus.out_word !== first[k]) begin miscompares++; $display("FAIL rerun_repeat[%0d] got=%h exp=%h", k, bus.out_word, first[k]); end
      end
      tick;
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rerun_done got=%b exp=1", done); end
    tick;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target_mm = 3'd0; count = 8'd0; bus.out_ready = 1'b0;
    m_lfsr = 16'hACE1;
    test_reset;
    test_palindrome;
    test_full_mismatch;
    test_stall;
    test_count_zero;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
